// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer
// Runs one inference of a 784-32-10 int8 MLP: streams layer-1 weight rows
// against frame-buffer pixels, applies bias/ReLU/requantisation, streams
// layer-2 rows against the hidden vector, adds layer-2 bias and performs a
// sequential argmax over the ten logits.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             one-cycle inference request, accepted only when idle
//   busy, done        busy from accepted start through done cycle; done pulse
//   pred, pred_logit  winning class and its logit, held until next done
//   layer_sel,row_idx weight-memory select (0 idle, 1 L1, 2 L2) and row
//   w1_in,b1_in       packed signed int8 layer-1 weights (row) and biases
//   w2_in,b2_in       packed signed int8 layer-2 weights (row) and biases
//   pixel_addr/_data  frame-buffer address and unsigned pixel
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// L1     | 784 cycles, acc1[j] += pixel[r] * w1[r][j]
// ACT1   | bias, ReLU, >>>SHIFT1, clamp to 127 into hidden regs
// L2     | 32 cycles, acc2[k] += h[r] * w2[r][k]
// BIAS2  | acc2[k] += b2[k]
// ARGMAX | 10 cycles, running max, strict greater keeps lowest index
// DONE   | done pulse, pred/pred_logit valid
module mlp_layer_sequencer #(
    parameter int N_IN   = 784,
    parameter int N_HID  = 32,
    parameter int N_OUT  = 10,
    parameter int SHIFT1 = 7,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              pred,
    output logic signed [ACC_W-1:0] pred_logit,
    output logic [1:0]              layer_sel,
    output logic [9:0]              row_idx,
    input  logic [8*N_HID-1:0]      w1_in,
    input  logic [8*N_HID-1:0]      b1_in,
    input  logic [8*N_OUT-1:0]      w2_in,
    input  logic [8*N_OUT-1:0]      b2_in,
    output logic [9:0]              pixel_addr,
    input  logic [7:0]              pixel_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_L1, S_ACT1, S_L2, S_BIAS2, S_ARGMAX, S_DONE
    } state_t;

    localparam logic [9:0] L1_LAST = 10'(N_IN - 1);
    localparam logic [9:0] L2_LAST = 10'(N_HID - 1);
    localparam logic [9:0] AM_LAST = 10'(N_OUT - 1);

    state_t                  state, state_nx;
    logic [9:0]              cnt;
    logic signed [ACC_W-1:0] acc1 [N_HID];
    logic signed [ACC_W-1:0] acc2 [N_OUT];
    logic signed [7:0]       hid [N_HID];
    logic signed [7:0]       hid_nx [N_HID];
    logic signed [ACC_W-1:0] act_sum [N_HID];
    logic signed [ACC_W-1:0] act_shr [N_HID];
    logic signed [ACC_W-1:0] best_val, cand_val, sel_val;
    logic [3:0]              best_idx, sel_idx;

    // Requantisation of the layer-1 sums into the hidden activations.
    always_comb begin
        for (int j = 0; j < N_HID; j++) begin
            act_sum[j] = acc1[j] + ACC_W'($signed(b1_in[8*j +: 8]));
            act_shr[j] = act_sum[j] >>> SHIFT1;
            if (act_sum[j] < 0)
                hid_nx[j] = 8'sd0;
            else if (act_shr[j] > ACC_W'(127))
                hid_nx[j] = 8'sd127;
            else
                hid_nx[j] = act_shr[j][7:0];
        end
    end

    // Running argmax; cnt==0 seeds the best with logit 0.
    always_comb begin
        cand_val = acc2[cnt[3:0]];
        sel_val  = best_val;
        sel_idx  = best_idx;
        if (cnt == 10'd0 || cand_val > best_val) begin
            sel_val = cand_val;
            sel_idx = cnt[3:0];
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b1;
        done       = 1'b0;
        layer_sel  = 2'd0;
        row_idx    = 10'd0;
        pixel_addr = 10'd0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_L1;
            end
            S_L1: begin
                layer_sel  = 2'd1;
                row_idx    = cnt;
                pixel_addr = cnt;
                if (cnt == L1_LAST) state_nx = S_ACT1;
            end
            S_ACT1: begin
                layer_sel = 2'd1;
                state_nx  = S_L2;
            end
            S_L2: begin
                layer_sel = 2'd2;
                row_idx   = cnt;
                if (cnt == L2_LAST) state_nx = S_BIAS2;
            end
            S_BIAS2: begin
                layer_sel = 2'd2;
                state_nx  = S_ARGMAX;
            end
            S_ARGMAX: begin
                if (cnt == AM_LAST) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 10'd0;
            best_val   <= '0;
            best_idx   <= 4'd0;
            pred       <= 4'd0;
            pred_logit <= '0;
            for (int j = 0; j < N_HID; j++) begin
                acc1[j] <= '0;
                hid[j]  <= 8'sd0;
            end
            for (int k = 0; k < N_OUT; k++) acc2[k] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt <= 10'd0;
                        for (int j = 0; j < N_HID; j++) acc1[j] <= '0;
                        for (int k = 0; k < N_OUT; k++) acc2[k] <= '0;
                    end
                end
                S_L1: begin
                    // Pixel is unsigned: zero-extend to 9 bits before the signed multiply.
                    for (int j = 0; j < N_HID; j++)
                        acc1[j] <= acc1[j] + ACC_W'($signed({1'b0, pixel_data}))
                                           * ACC_W'($signed(w1_in[8*j +: 8]));
                    cnt <= (cnt == L1_LAST) ? 10'd0 : cnt + 10'd1;
                end
                S_ACT1: begin
                    for (int j = 0; j < N_HID; j++) hid[j] <= hid_nx[j];
                    cnt <= 10'd0;
                end
                S_L2: begin
                    for (int k = 0; k < N_OUT; k++)
                        acc2[k] <= acc2[k] + ACC_W'(hid[cnt[4:0]])
                                           * ACC_W'($signed(w2_in[8*k +: 8]));
                    cnt <= (cnt == L2_LAST) ? 10'd0 : cnt + 10'd1;
                end
                S_BIAS2: begin
                    for (int k = 0; k < N_OUT; k++)
                        acc2[k] <= acc2[k] + ACC_W'($signed(b2_in[8*k +: 8]));
                    cnt <= 10'd0;
                end
                S_ARGMAX: begin
                    best_val <= sel_val;
                    best_idx <= sel_idx;
                    cnt      <= cnt + 10'd1;
                    // Publish on the last compare so pred is valid during done.
                    if (cnt == AM_LAST) begin
                        pred       <= sel_idx;
                        pred_logit <= sel_val;
                    end
                end
                default: cnt <= 10'd0;
            endcase
        end
    end

endmodule
